// File: rtl/lsq_pkg.sv
// lsq_pkg: shared types and helpers for the load/store memory scheduler.
package lsq_pkg;

  localparam int XLEN = 32;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ_LD  = 2'd1,
    S_REQ_ST  = 2'd2,
    S_WAIT_LD = 2'd3
  } sched_state_t;

  // One retired store waiting for commit.
  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic            is_byte;
  } st_entry_t;

  // Shape returned memory data into the load result: whole word for LW,
  // sign-extended addressed byte for LB.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] rdata,
                                                  input logic [1:0]      offs,
                                                  input logic            is_byte);
    logic [7:0] b;
    b = rdata[{offs, 3'b000} +: 8];
    if (is_byte) begin
      return {{(XLEN-8){b[7]}}, b};
    end
    return rdata;
  endfunction

endpackage

// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order FIFO of retired stores with two push ports
// and one pop port. Per-entry valid/word-address vectors feed the load
// hazard compare in the scheduler.
module store_commit_buffer
  import lsq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push1,
  input  st_entry_t                       push1_entry,
  input  logic                            push2,
  input  st_entry_t                       push2_entry,
  input  logic                            pop,
  output st_entry_t                       head,
  output logic [$clog2(DEPTH):0]          count,
  output logic                            full,
  output logic                            empty,
  output logic [DEPTH-1:0]                ent_valid,
  output logic [DEPTH-1:0][XLEN-3:0]      ent_waddr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  st_entry_t     entries_q [DEPTH];
  st_entry_t     entries_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          accept;
  logic          do_push1, do_push2, do_pop;
  logic [PW-1:0] wr_slot2;

  // Pushes are only taken when two slots are free, so a dual retire never
  // has to be split; anything offered without room is dropped.
  assign accept   = (count_q <= CW'(DEPTH - 2));
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push1 = push1 && accept;
  assign do_push2 = push2 && accept;
  assign do_pop   = pop && !empty;
  assign wr_slot2 = do_push1 ? wr_ptr_q + PW'(1) : wr_ptr_q;

  assign head  = entries_q[rd_ptr_q];
  assign count = count_q;

  // Next-state for storage, pointers and occupancy (port 1 ahead of port 2).
  always_comb begin
    entries_d = entries_q;
    if (do_push1) begin
      entries_d[wr_ptr_q] = push1_entry;
    end
    if (do_push2) begin
      entries_d[wr_slot2] = push2_entry;
    end
    wr_ptr_d = wr_ptr_q + PW'(do_push1) + PW'(do_push2);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push1) + CW'(do_push2) - CW'(do_pop);
  end

  // Register FIFO state.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Slot gi is live when its distance from the read pointer is below count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    logic [PW-1:0] offs;
    assign offs          = PW'(gi) - rd_ptr_q;
    assign ent_valid[gi] = ({1'b0, offs} < count_q);
    assign ent_waddr[gi] = entries_q[gi].addr[XLEN-1:2];
  end

endmodule

// File: rtl/lsq_mem_scheduler.sv
// lsq_mem_scheduler: arbitrates the single data-memory port between LSQ
// loads and retired stores held in the commit buffer, with a load-over-store
// hazard check and a bound on how long stores can be starved by loads.
module lsq_mem_scheduler
  import lsq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int SB_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [XLEN-1:0] ld_pc,
  input  logic [XLEN-1:0] ld_addr,
  input  logic            ld_byte,
  input  logic            st_valid1,
  input  logic [XLEN-1:0] st_addr1,
  input  logic [XLEN-1:0] st_data1,
  input  logic            st_byte1,
  input  logic            st_valid2,
  input  logic [XLEN-1:0] st_addr2,
  input  logic [XLEN-1:0] st_data2,
  input  logic            st_byte2,
  output logic            st_ready,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_byte,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            ld_done,
  output logic [XLEN-1:0] ld_done_pc,
  output logic [XLEN-1:0] ld_done_data,
  output logic            sb_empty
);

  localparam int CW  = $clog2(SB_DEPTH) + 1;
  localparam int SWW = $clog2(STARVE_MAX + 1);

  st_entry_t                    st_entry1, st_entry2, sb_head;
  logic [CW-1:0]                sb_count;
  logic                         sb_full, sb_is_empty;
  logic [SB_DEPTH-1:0]          sb_valid;
  logic [SB_DEPTH-1:0][XLEN-3:0] sb_waddr;
  logic [SB_DEPTH-1:0]          ld_match;
  logic                         hazard, starve, block_ld, go_st;

  sched_state_t    state_q, state_d;
  logic [SWW-1:0]  store_wait_q, store_wait_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            mem_byte_q, mem_byte_d;
  logic [XLEN-1:0] ld_pc_q, ld_pc_d;
  logic            ld_done_q, ld_done_d;
  logic [XLEN-1:0] ld_done_pc_q, ld_done_pc_d;
  logic [XLEN-1:0] ld_done_data_q, ld_done_data_d;

  assign st_entry1 = '{addr: st_addr1, data: st_data1, is_byte: st_byte1};
  assign st_entry2 = '{addr: st_addr2, data: st_data2, is_byte: st_byte2};

  store_commit_buffer #(
    .DEPTH(SB_DEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push1      (st_valid1),
    .push1_entry(st_entry1),
    .push2      (st_valid2),
    .push2_entry(st_entry2),
    .pop        (go_st),
    .head       (sb_head),
    .count      (sb_count),
    .full       (sb_full),
    .empty      (sb_is_empty),
    .ent_valid  (sb_valid),
    .ent_waddr  (sb_waddr)
  );

  // A load may not bypass a buffered store to the same word.
  for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_hazard
    assign ld_match[gi] = sb_valid[gi] && (sb_waddr[gi] == ld_addr[XLEN-1:2]);
  end

  assign hazard   = ld_valid && (|ld_match);
  assign starve   = (store_wait_q == SWW'(STARVE_MAX)) && !sb_is_empty;
  assign block_ld = sb_full || hazard || starve;
  assign ld_ready = (state_q == S_IDLE) && ld_valid && !block_ld;
  // Every reason to pick a store implies the buffer holds at least one entry.
  assign go_st    = (state_q == S_IDLE) && (block_ld || (!ld_valid && !sb_is_empty));

  assign st_ready     = (sb_count <= CW'(SB_DEPTH - 2));
  assign sb_empty     = sb_is_empty;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign mem_byte     = mem_byte_q;
  assign ld_done      = ld_done_q;
  assign ld_done_pc   = ld_done_pc_q;
  assign ld_done_data = ld_done_data_q;

  // FSM next-state and registered request/response outputs.
  always_comb begin
    state_d        = state_q;
    store_wait_d   = store_wait_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_byte_d     = mem_byte_q;
    ld_pc_d        = ld_pc_q;
    ld_done_d      = 1'b0;
    ld_done_pc_d   = ld_done_pc_q;
    ld_done_data_d = ld_done_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_st) begin
          state_d      = S_REQ_ST;
          store_wait_d = '0;
          mem_req_d    = 1'b1;
          mem_we_d     = 1'b1;
          mem_addr_d   = sb_head.addr;
          mem_wdata_d  = sb_head.data;
          mem_byte_d   = sb_head.is_byte;
        end else if (ld_ready) begin
          state_d     = S_REQ_LD;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = ld_addr;
          mem_wdata_d = '0;
          mem_byte_d  = ld_byte;
          ld_pc_d     = ld_pc;
          if (!sb_is_empty && (store_wait_q != SWW'(STARVE_MAX))) begin
            store_wait_d = store_wait_q + SWW'(1);
          end
        end
      end
      S_REQ_LD: begin
        if (mem_gnt) begin
          state_d   = S_WAIT_LD;
          mem_req_d = 1'b0;
        end
      end
      S_REQ_ST: begin
        if (mem_gnt) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      S_WAIT_LD: begin
        if (mem_rvalid) begin
          state_d        = S_IDLE;
          ld_done_d      = 1'b1;
          ld_done_pc_d   = ld_pc_q;
          ld_done_data_d = load_extend(mem_rdata, mem_addr_q[1:0], mem_byte_q);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Scheduler state register; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      store_wait_q   <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_byte_q     <= 1'b0;
      ld_pc_q        <= '0;
      ld_done_q      <= 1'b0;
      ld_done_pc_q   <= '0;
      ld_done_data_q <= '0;
    end else begin
      state_q        <= state_d;
      store_wait_q   <= store_wait_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_byte_q     <= mem_byte_d;
      ld_pc_q        <= ld_pc_d;
      ld_done_q      <= ld_done_d;
      ld_done_pc_q   <= ld_done_pc_d;
      ld_done_data_q <= ld_done_data_d;
    end
  end

endmodule
